// File: rtl/window_read_control.sv
`default_nettype none
// ============================================================================
// Module      : window_read_control
// Description : Walks a KxK convolution window across an image held in IMG_W
//               processing units of K row slots each. Emits one tap address
//               per accepted beat, frees the oldest row slot after each
//               output row, and waits for the writer to refill before moving on.
// Revision    : 1.0 - initial release
// ============================================================================
module window_read_control #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 5
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  input  logic       row_commit,
  input  logic       rd_ready,
  output logic       rd_valid,
  output logic [5:0] rd_PU_No,
  output logic [5:0] rd_add,
  output logic [5:0] out_row,
  output logic [5:0] out_col,
  output logic       last_tap,
  output logic       row_release,
  output logic       busy,
  output logic       done,
  output logic       overflow_err
);

  localparam logic [5:0] c_K        = 6'(K);
  localparam logic [5:0] c_K_M1     = 6'(K - 1);
  localparam logic [5:0] c_COL_LAST = 6'(IMG_W - K);
  localparam logic [5:0] c_ROW_LAST = 6'(IMG_H - K);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_ROWS = 3'd1,
    S_READING   = 3'd2,
    S_RELEASE   = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_kc;
  logic [5:0] r_kr;
  logic [5:0] r_base_slot;
  logic [5:0] r_rows_avail;
  logic [5:0] r_out_row;
  logic [5:0] r_out_col;
  logic       r_overflow;
  logic       w_accept;
  logic       w_last_tap;
  logic       w_release;
  logic [6:0] w_add_sum;
  logic [6:0] w_add_mod;

  // Beat handshake and window-corner detection.
  assign w_accept   = (r_state == S_READING) && rd_ready;
  assign w_last_tap = (r_kr == c_K_M1) && (r_kc == c_K_M1);
  assign w_release  = (r_state == S_RELEASE);

  // Slot index is formed at 7 bits so base_slot + kr (up to 2K-2) never wraps.
  assign w_add_sum = {1'b0, r_base_slot} + {1'b0, r_kr};
  assign w_add_mod = (w_add_sum >= {1'b0, c_K}) ? (w_add_sum - {1'b0, c_K}) : w_add_sum;

  assign rd_PU_No     = r_out_col + r_kc;
  assign rd_add       = w_add_mod[5:0];
  assign out_row      = r_out_row;
  assign out_col      = r_out_col;
  assign last_tap     = w_last_tap;
  assign overflow_err = r_overflow;

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    rd_valid    = 1'b0;
    row_release = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = S_WAIT_ROWS;
      end
      S_WAIT_ROWS: begin
        if (r_rows_avail == c_K) w_state_nxt = S_READING;
      end
      S_READING: begin
        rd_valid = 1'b1;
        if (w_accept && w_last_tap && (r_out_col == c_COL_LAST)) w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        row_release = 1'b1;
        w_state_nxt = (r_out_row == c_ROW_LAST) ? S_DONE : S_WAIT_ROWS;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Window walk: kc innermost, then kr, then out_col; row advance on release.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_kc        <= '0;
      r_kr        <= '0;
      r_out_col   <= '0;
      r_out_row   <= '0;
      r_base_slot <= '0;
    end else if (r_state == S_IDLE) begin
      r_kc        <= '0;
      r_kr        <= '0;
      r_out_col   <= '0;
      r_out_row   <= '0;
      r_base_slot <= '0;
    end else if (w_accept) begin
      if (r_kc == c_K_M1) begin
        r_kc <= '0;
        if (r_kr == c_K_M1) begin
          r_kr      <= '0;
          r_out_col <= (r_out_col == c_COL_LAST) ? 6'd0 : r_out_col + 6'd1;
        end else begin
          r_kr <= r_kr + 6'd1;
        end
      end else begin
        r_kc <= r_kc + 6'd1;
      end
    end else if (w_release) begin
      r_base_slot <= (r_base_slot == c_K_M1) ? 6'd0 : r_base_slot + 6'd1;
      r_out_row   <= r_out_row + 6'd1;
    end
  end

  // Row-slot occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rows_avail <= '0;
      r_overflow   <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_rows_avail <= '0;
      if (start) r_overflow <= 1'b0;
    end else begin
      case ({row_commit, w_release})
        2'b10: begin
          if (r_rows_avail == c_K) r_overflow   <= 1'b1;
          else                     r_rows_avail <= r_rows_avail + 6'd1;
        end
        2'b01: begin
          if (r_rows_avail != 6'd0) r_rows_avail <= r_rows_avail - 6'd1;
        end
        default: r_rows_avail <= r_rows_avail;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_window_read_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_read_control
// Description : Randomised bench for window_read_control. Expected taps come
//               from the beat index decomposed into row/col/kr/kc arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_read_control;

  localparam int IMG_W     = 28;
  localparam int IMG_H     = 28;
  localparam int K         = 5;
  localparam int BEATS_ROW = (IMG_W - K + 1) * K * K;
  localparam int N_ROWS    = IMG_H - K + 1;
  localparam int STALL_AT  = 1002;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       start = 1'b0;
  logic       row_commit = 1'b0;
  logic       rd_ready = 1'b0;
  logic       rd_valid;
  logic [5:0] rd_PU_No;
  logic [5:0] rd_add;
  logic [5:0] out_row;
  logic [5:0] out_col;
  logic       last_tap;
  logic       row_release;
  logic       busy;
  logic       done;
  logic       overflow_err;

  int n_checks = 0;
  int n_fail   = 0;

  window_read_control #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)) dut (
    .clk(clk), .nrst(nrst), .start(start), .row_commit(row_commit),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_PU_No(rd_PU_No),
    .rd_add(rd_add), .out_row(out_row), .out_col(out_col),
    .last_tap(last_tap), .row_release(row_release), .busy(busy),
    .done(done), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected tap for beat n of the frame, from plain index arithmetic.
  task automatic check_tap(input int n);
    int r, m, col, kr, kc;
    r   = n / BEATS_ROW;
    m   = n % BEATS_ROW;
    col = m / (K * K);
    kr  = (m % (K * K)) / K;
    kc  = m % K;
    check("tap_pu",   rd_PU_No, col + kc);
    check("tap_add",  rd_add,   (r + kr) % K);
    check("tap_row",  out_row,  r);
    check("tap_col",  out_col,  col);
    check("tap_last", last_tap, (kr == K - 1 && kc == K - 1) ? 1 : 0);
  endtask

  task automatic run_frame(input bit inj_ovf, input int reset_at,
                           output int beats, output int rels, output int dns, output int commits);
    int held = 0;
    int cyc = 0;
    int stall = 0;
    int c39 = 0;
    bit fin = 0;
    bit stall_done = 0;
    bit ovf_done = 0;
    bit ovf_pend = 0;
    beats = 0; rels = 0; dns = 0; commits = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ovf_clear_on_start", overflow_err, 0);
    check("busy_after_start", busy, 1);
    while (!fin && cyc < 40000) begin
      if (reset_at >= 0 && beats >= reset_at) break;
      row_commit = 1'b0;
      if (c39 == 2) begin
        check("simul_resume_valid", rd_valid, 1);
        c39 = 0;
      end
      if (c39 == 1) begin
        check("simul_rows_avail", dut.r_rows_avail, K);
        check("simul_wait_valid", rd_valid, 0);
        c39 = 2;
      end
      if (ovf_pend) begin
        check("ovf_rows_avail", dut.r_rows_avail, K);
        check("ovf_flag", overflow_err, 1);
        ovf_pend = 0;
      end
      if (row_release) begin rels++; held--; end
      if (done) begin dns++; fin = 1; end
      if (rd_valid) begin
        check_tap(beats);
        if (beats == 599) begin
          check("addr_corner_pu", rd_PU_No, 27);
          check("addr_corner_add", rd_add, 4);
          check("addr_corner_last", last_tap, 1);
        end
        if (beats == BEATS_ROW) check("addr_row1_add", rd_add, 1);
      end
      if (rd_valid && beats == STALL_AT && !stall_done) begin
        stall = 10;
        stall_done = 1;
      end
      if (stall > 0) begin
        rd_ready = 1'b0;
        stall--;
      end else begin
        rd_ready = ($urandom_range(3, 0) != 0);
      end
      if (rd_valid && rd_ready) beats++;
      if (busy && !done && commits < IMG_H && held < K) begin
        if (row_release && rels[0]) begin
          row_commit = 1'b1;
          c39 = 1;
        end else begin
          row_commit = 1'($urandom_range(1, 0));
        end
        if (row_commit) begin held++; commits++; end
      end else if (inj_ovf && !ovf_done && busy && held == K && rels == 0) begin
        row_commit = 1'b1;
        ovf_done = 1;
        ovf_pend = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    row_commit = 1'b0;
    if (reset_at < 0) check("frame_finished", fin, 1);
  endtask

  initial begin
    int beats, rels, dns, commits;
    int rel_cnt, done_cnt;
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", rd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_pu", rd_PU_No, 0);
    check("rst_add", rd_add, 0);
    check("rst_ovf", overflow_err, 0);
    check("rst_done", done, 0);
    nrst = 1'b1;
    @(posedge clk); #1;

    // Full frame with one extra commit to provoke overflow.
    run_frame(1'b1, -1, beats, rels, dns, commits);
    check("frame_beats", beats, N_ROWS * BEATS_ROW);
    check("frame_releases", rels, N_ROWS);
    check("frame_done_pulses", dns, 1);
    check("frame_commits", commits, IMG_H);
    @(posedge clk); #1;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("ovf_sticky", overflow_err, 1);

    // Second frame, reset asserted mid-Reading.
    run_frame(1'b0, 300, beats, rels, dns, commits);
    check("pre_reset_valid", rd_valid, 1);
    nrst = 1'b0;
    #2;
    check("midrst_valid", rd_valid, 0);
    check("midrst_pu", rd_PU_No, 0);
    check("midrst_add", rd_add, 0);
    check("midrst_busy", busy, 0);
    check("midrst_col", out_col, 0);
    check("midrst_last", last_tap, 0);
    @(posedge clk); #1;
    nrst = 1'b1;
    rel_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      row_commit = 1'($urandom_range(1, 0));
      rd_ready = 1'b1;
      @(posedge clk); #1;
      if (row_release) rel_cnt++;
      if (done) done_cnt++;
    end
    row_commit = 1'b0;
    check("postrst_releases", rel_cnt, 0);
    check("postrst_done", done_cnt, 0);
    check("postrst_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/window_read_control.md
WINDOW_READ_CONTROL -- requirements
Module: window_read_control

Interface
REQ-001 SHALL have parameter IMG_W, default 28, image width in pixels, which is also the number of PUs.
REQ-002 SHALL have parameter IMG_H, default 28, image height in rows.
REQ-003 SHALL have parameter K, default 5, kernel size, which is also the number of row slots per PU.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port nrst  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start  input  1  frame start; sampled in Idle only.
REQ-007 SHALL have port row_commit  input  1  one-cycle pulse from the mapping writer when a full image row has been stored in the PUs.
REQ-008 SHALL have port rd_ready  input  1  downstream accepts the current tap.
REQ-009 SHALL have port rd_valid  output  1  current tap address is valid.
REQ-010 SHALL have port rd_PU_No  output  6  PU to read; equals out_col + kc.
REQ-011 SHALL have port rd_add  output  6  row slot in the PU; equals (base_slot + kr) mod K.
REQ-012 SHALL have ports out_row and out_col  output  6 each  output pixel coordinate of the current window.
REQ-013 SHALL have port last_tap  output  1  high when kr == K-1 and kc == K-1.
REQ-014 SHALL have port row_release  output  1  one-cycle pulse freeing the oldest row slot to the writer.
REQ-015 SHALL have ports busy, done, overflow_err  output  1 each  busy = state is not Idle; done = one-cycle pulse at end of frame; overflow_err = sticky error flag.

Function
REQ-016 SHALL implement states Idle, Wait_Rows, Reading, Release and Done.
REQ-017 SHALL have internal counters kc and kr (range 0..K-1), base_slot (0..K-1) and rows_avail (0..K), all 6-bit.
REQ-018 SHALL, in Idle, hold all counters at 0 and rows_avail at 0, and move to Wait_Rows on start.
REQ-019 SHALL, outside Idle, update rows_avail by +1 on row_commit and by -1 on row_release, and leave it unchanged when both occur in the same cycle.
REQ-020 SHALL, when row_commit arrives with rows_avail == K and no release in that cycle, leave rows_avail at K and set overflow_err, which stays set until reset or the next start.
REQ-021 SHALL, in Wait_Rows, move to Reading in the cycle after rows_avail == K is registered.
REQ-022 SHALL hold rd_valid at 1 throughout Reading and at 0 in all other states.
REQ-023 SHALL advance one tap per cycle in which rd_valid && rd_ready, with kc innermost, then kr, then out_col over 0..IMG_W-K.
REQ-024 SHALL keep all address outputs registered and stable while rd_valid && !rd_ready.
REQ-025 SHALL, on the accepted beat with last_tap and out_col == IMG_W-K, move to Release and clear kc, kr and out_col.
REQ-026 SHALL, in Release, assert row_release for exactly one cycle, set base_slot = (base_slot+1) mod K, and increment out_row.
REQ-027 SHALL leave Release for Done if out_row was IMG_H-K, and for Wait_Rows otherwise.
REQ-028 SHALL require that the next row can start only after one new row_commit brings rows_avail back to K.
REQ-029 SHALL, in Done, assert done for one cycle and then return to Idle.
REQ-030 SHALL ignore start in every state except Idle.
REQ-031 SHALL wrap base_slot from K-1 to 0, and SHALL compute rd_add without truncation in the intermediate sum (at most 2K-2 before the mod).
REQ-032 SHALL keep rd_PU_No within 0..IMG_W-1 at all times.

Reset
REQ-033 SHALL, while nrst = 0, set the state to Idle and drive every output and internal counter to 0, including overflow_err, regardless of the current state.
REQ-034 SHALL, after reset is released mid-frame, issue no row_release or done until a new start.

Verification
REQ-035 SHALL be checked for reset: nrst low during Reading -> next sample shows rd_valid=0, rd_PU_No=0, rd_add=0, busy=0.
REQ-036 SHALL be checked for a full frame: start, 28 row_commit pulses issued on demand, rd_ready=1 -> exactly 24*24*25 = 14400 accepted beats, 24 row_release pulses, then one done pulse.
REQ-037 SHALL be checked for addressing: first output row, out_col=23, kr=4, kc=4 -> rd_PU_No=27, rd_add=4, last_tap=1; second output row, kr=0 -> rd_add=1.
REQ-038 SHALL be checked for backpressure: rd_ready held 0 for 10 cycles mid-window -> outputs frozen, no taps lost or duplicated.
REQ-039 SHALL be checked for simultaneous events: row_commit in the same cycle as row_release -> rows_avail stays 5 and Reading resumes after one Wait_Rows cycle.
REQ-040 SHALL be checked for overflow: 6 row_commit pulses before any release -> rows_avail=5, overflow_err=1, and overflow_err clears on the next start.
